// File: rtl/panel_row_shifter.sv
// panel_row_shifter: shifts one row word MSB-first into daisy-chained LED drivers,
// then blanks the panel, switches the row select and pulses LATCH.
module panel_row_shifter #(
   parameter int DATA_WIDTH   = 48,
   parameter int ROW_BITS     = 4,
   parameter int CLK_DIV      = 4,
   parameter int BLANK_CYCLES = 8
) (
   input  logic                  CLOCK_50,
   input  logic                  RESET,
   input  logic [DATA_WIDTH-1:0] row_data,
   input  logic [ROW_BITS-1:0]   row_addr,
   input  logic                  row_valid,
   output logic                  row_ready,
   output logic                  SER,
   output logic                  SCLK,
   output logic                  LATCH,
   output logic                  BLANK,
   output logic [ROW_BITS-1:0]   ROW,
   output logic                  busy
);
   localparam int CMAX = CLK_DIV > BLANK_CYCLES ? CLK_DIV : BLANK_CYCLES;
   localparam int CW   = $clog2(CMAX) + 1;
   localparam int BW   = $clog2(DATA_WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_BLANK, S_LATCH} state_t;

   state_t                state, state_d;
   logic [CW-1:0]         cnt, cnt_d;
   logic [BW-1:0]         bit_cnt, bit_d;
   logic                  phase, phase_d;
   logic [DATA_WIDTH-2:0] rest, rest_d;
   logic [ROW_BITS-1:0]   pending, pend_d, row_d;
   logic                  shown, shown_d;
   logic                  ser_d, sclk_d, latch_d, blank_d;
   logic                  hs, tick, last_bit;

   assign row_ready = state == S_IDLE && !RESET;
   assign busy      = state != S_IDLE;
   assign hs        = row_valid && row_ready;
   assign tick      = cnt == (state == S_BLANK ? CW'(BLANK_CYCLES - 1) : CW'(CLK_DIV - 1));
   assign last_bit  = bit_cnt == BW'(DATA_WIDTH - 1);

   always_ff @(posedge CLOCK_50)
      state <= RESET ? S_IDLE : state_d;

   always_comb begin
      state_d = state;
      case (state)
         S_IDLE:  state_d = hs ? S_SHIFT : S_IDLE;
         S_SHIFT: state_d = tick && phase && last_bit ? S_BLANK : S_SHIFT;
         S_BLANK: state_d = tick ? S_LATCH : S_BLANK;
         S_LATCH: state_d = tick ? S_IDLE : S_LATCH;
         default: state_d = S_IDLE;
      endcase
   end

   // SER is the top of the shift register; the last shift leaves it zero.
   always_comb begin
      {ser_d, rest_d} = {SER, rest};
      sclk_d  = SCLK;
      latch_d = LATCH;
      blank_d = BLANK;
      row_d   = ROW;
      shown_d = shown;
      pend_d  = pending;
      phase_d = phase;
      bit_d   = bit_cnt;
      cnt_d   = tick ? '0 : cnt + 1'b1;
      case (state)
         S_IDLE: begin
            cnt_d   = '0;
            blank_d = !shown;
            if (hs) begin
               {ser_d, rest_d} = row_data;
               pend_d  = row_addr;
               bit_d   = '0;
               phase_d = 1'b0;
            end
         end
         S_SHIFT: if (tick) begin
            phase_d = !phase;
            sclk_d  = !phase;
            if (phase) begin
               {ser_d, rest_d} = {rest, 1'b0};
               bit_d   = bit_cnt + 1'b1;
               blank_d = last_bit | BLANK;
            end
         end
         S_BLANK: if (tick) begin
            latch_d = 1'b1;
            row_d   = pending;
         end
         S_LATCH: if (tick) begin
            latch_d = 1'b0;
            blank_d = 1'b0;
            shown_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         SER     <= 1'b0;
         rest    <= '0;
         SCLK    <= 1'b0;
         LATCH   <= 1'b0;
         BLANK   <= 1'b1;
         ROW     <= '0;
         shown   <= 1'b0;
         pending <= '0;
         phase   <= 1'b0;
         bit_cnt <= '0;
         cnt     <= '0;
      end else begin
         SER     <= ser_d;
         rest    <= rest_d;
         SCLK    <= sclk_d;
         LATCH   <= latch_d;
         BLANK   <= blank_d;
         ROW     <= row_d;
         shown   <= shown_d;
         pending <= pend_d;
         phase   <= phase_d;
         bit_cnt <= bit_d;
         cnt     <= cnt_d;
      end
   end
endmodule

// File: tb/tb_panel_row_shifter.sv
// tb_panel_row_shifter: cycle-indexed reference model on a small instance,
// plus a waveform measurement on a default-parameter instance.
module tb_panel_row_shifter;
   localparam int DW = 8, CD = 2, BC = 3;
   localparam int S = 2 * CD * DW, T = S + BC + CD;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          RESET = 1'b1, row_valid = 1'b0, row_ready;
   logic [DW-1:0] row_data = '0;
   logic [3:0]    row_addr = '0, ROW;
   logic          SER, SCLK, LATCH, BLANK, busy;

   logic          rst_b = 1'b1, valid_b = 1'b0, ready_b;
   logic [47:0]   data_b = '0;
   logic [3:0]    addr_b = '0, row_b;
   logic          ser_b, sclk_b, latch_b, blank_b, busy_b;

   panel_row_shifter #(.DATA_WIDTH(DW), .ROW_BITS(4), .CLK_DIV(CD), .BLANK_CYCLES(BC)) dut (
      .CLOCK_50(clk), .RESET(RESET), .row_data(row_data), .row_addr(row_addr),
      .row_valid(row_valid), .row_ready(row_ready), .SER(SER), .SCLK(SCLK),
      .LATCH(LATCH), .BLANK(BLANK), .ROW(ROW), .busy(busy)
   );

   panel_row_shifter dut_b (
      .CLOCK_50(clk), .RESET(rst_b), .row_data(data_b), .row_addr(addr_b),
      .row_valid(valid_b), .row_ready(ready_b), .SER(ser_b), .SCLK(sclk_b),
      .LATCH(latch_b), .BLANK(blank_b), .ROW(row_b), .busy(busy_b)
   );

   int total = 0, bad = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // model: a row in flight is described only by its cycle index k since acceptance
   bit            m_active = 1'b0, m_shown = 1'b0;
   int            m_k = 0, n_acc = 0;
   logic [DW-1:0] m_d = '0;
   logic [3:0]    m_a = '0, m_row = '0;

   task automatic cyc(input logic v, input logic [DW-1:0] d, input logic [3:0] a, input logic r);
      row_valid = v;
      row_data  = d;
      row_addr  = a;
      RESET     = r;
      #1 chk("ready", row_ready, !m_active && !r);
      @(posedge clk);
      if (r) begin
         m_active = 1'b0;
         m_shown  = 1'b0;
         m_row    = '0;
      end else if (!m_active) begin
         if (v) begin
            m_active = 1'b1;
            m_k      = 0;
            m_d      = d;
            m_a      = a;
            n_acc++;
         end
      end else begin
         m_k++;
         if (m_k == S + BC) m_row = m_a;
         if (m_k == T) begin
            m_active = 1'b0;
            m_shown  = 1'b1;
         end
      end
      #1;
      chk("sclk", SCLK, m_active && m_k < S && (m_k / CD) % 2 == 1);
      chk("ser", SER, (m_active && m_k < S) ? m_d[DW-1-m_k/(2*CD)] : 1'b0);
      chk("latch", LATCH, m_active && m_k >= S + BC);
      chk("blank", BLANK, !m_shown || (m_active && m_k >= S));
      chk("row", ROW, m_row);
      chk("busy", busy, m_active);
   endtask

   initial begin
      int base, rises, first_l, last_l, first_r;
      logic [47:0] ser_bits;
      logic sclk_prev;
      repeat (3) cyc(1'b0, '0, '0, 1'b1);
      repeat (4) cyc(1'b0, DW'($urandom), 4'($urandom), 1'b0);
      cyc(1'b1, 8'hA5, 4'd3, 1'b0);
      repeat (40) cyc(1'b0, DW'($urandom), 4'($urandom), 1'b0);
      base = n_acc;
      for (int i = 0; i < 2 * (T + 1) + 4; i++)
         cyc(n_acc < base + 2, n_acc == base ? 8'hFF : 8'h00, n_acc == base ? 4'd1 : 4'd2, 1'b0);
      chk("b2b_count", n_acc, base + 2);
      cyc(1'b1, DW'($urandom), 4'($urandom), 1'b0);
      repeat (10) cyc(1'b0, DW'($urandom), 4'($urandom), 1'b0);
      cyc(1'b0, DW'($urandom), 4'($urandom), 1'b1);
      repeat (40) cyc(1'b0, DW'($urandom), 4'($urandom), 1'b0);
      cyc(1'b1, DW'($urandom), 4'($urandom), 1'b0);
      repeat (40) cyc(1'b0, DW'($urandom), 4'($urandom), 1'b0);
      for (int i = 0; i < 1500; i++)
         cyc($urandom % 3 != 0, DW'($urandom), 4'($urandom), $urandom % 150 == 0);

      // default parameters: measure one full row on the second instance
      repeat (2) @(posedge clk);
      #1 rst_b = 1'b0;
      chk("b_reset_busy", busy_b, 1'b0);
      chk("b_reset_blank", blank_b, 1'b1);
      valid_b = 1'b1;
      data_b  = 48'h800000000001;
      addr_b  = 4'd15;
      #1 chk("b_ready_idle", ready_b, 1'b1);
      @(posedge clk);
      #1 valid_b = 1'b0;
      data_b    = {$urandom, 16'($urandom)};
      rises     = 0;
      first_l   = -1;
      last_l    = -1;
      first_r   = -1;
      ser_bits  = '0;
      sclk_prev = 1'b0;
      for (int k = 0; k < 400; k++) begin
         if (sclk_b && !sclk_prev) begin
            rises++;
            ser_bits = {ser_bits[46:0], ser_b};
         end
         sclk_prev = sclk_b;
         if (latch_b) begin
            if (first_l < 0) first_l = k;
            last_l = k;
         end
         if (ready_b) begin
            first_r = k;
            break;
         end
         @(posedge clk);
         #1;
      end
      chk("b_rises", rises, 48);
      chk("b_ser_bits", ser_bits, 48'h800000000001);
      chk("b_latch_first", first_l, 392);
      chk("b_latch_last", last_l, 395);
      chk("b_ready_cycle", first_r, 396);
      chk("b_row", row_b, 4'd15);
      chk("b_blank_after", blank_b, 1'b0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
